// File: rtl/clk_sched_pkg.sv
// Shared constants and config FSM state type for the clock-enable scheduler.
package clk_sched_pkg;

    localparam int unsigned DEFAULT_TC = 49999;

    typedef enum logic [1:0] {
        StIdle,
        StWaitWrap,
        StAlign
    } cfg_state_e;

endpackage

// File: rtl/clk_en_chan.sv
// One divider channel: wrap counter, live/pending terminal count, tick strobe and toggle.
module clk_en_chan #(
    parameter int unsigned CW         = 18,
    parameter int unsigned DEFAULT_TC = clk_sched_pkg::DEFAULT_TC
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          load,
    input  logic [CW-1:0] load_tc,
    input  logic          align,
    output logic          tick,
    output logic          toggle,
    output logic          pend
);

    localparam logic [CW-1:0] TcRst = CW'(DEFAULT_TC);

    logic [CW-1:0] cnt;
    logic [CW-1:0] tc;
    logic [CW-1:0] tc_pend;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            tc      <= TcRst;
            tc_pend <= TcRst;
            pend    <= 1'b0;
            tick    <= 1'b0;
            toggle  <= 1'b0;
        end else if (align) begin
            // Realign restarts every channel from a common phase.
            cnt    <= '0;
            tick   <= 1'b0;
            toggle <= 1'b0;
            pend   <= 1'b0;
            if (pend) tc <= tc_pend;
        end else begin
            // load only arrives while pend is clear, so it never races the apply below.
            if (load) begin
                tc_pend <= load_tc;
                pend    <= 1'b1;
            end
            if (en) begin
                if (cnt == tc) begin
                    cnt    <= '0;
                    tick   <= 1'b1;
                    toggle <= ~toggle;
                    if (pend) begin
                        tc   <= tc_pend;
                        pend <= 1'b0;
                    end
                end else begin
                    cnt  <= cnt + 1'b1;
                    tick <= 1'b0;
                end
            end else begin
                tick <= 1'b0;
                if (pend) begin
                    tc   <= tc_pend;
                    cnt  <= '0;
                    pend <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/clk_en_sched.sv
// Programmable clock-enable scheduler: NCH divider channels behind a valid/ready config port.
module clk_en_sched #(
    parameter int unsigned NCH        = 3,
    parameter int unsigned CW         = 18,
    parameter int unsigned DEFAULT_TC = clk_sched_pkg::DEFAULT_TC,
    localparam int unsigned CHW       = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic           CLK100MHz,
    input  logic           RST_N,
    input  logic           CFG_VALID,
    output logic           CFG_READY,
    input  logic [CHW-1:0] CFG_CH,
    input  logic [CW-1:0]  CFG_TC,
    input  logic           CFG_SYNC,
    input  logic [NCH-1:0] EN_MASK,
    output logic [NCH-1:0] TICK,
    output logic [NCH-1:0] TOGGLE,
    output logic [NCH-1:0] PENDING
);

    import clk_sched_pkg::*;

    cfg_state_e     state;
    logic [CHW-1:0] tgt;
    logic           ch_valid;
    logic           accept;
    logic [NCH-1:0] load;
    logic           align;

    assign ch_valid = 32'(CFG_CH) < NCH;
    assign accept   = CFG_VALID && CFG_READY;
    assign align    = (state == StAlign);

    always_comb begin
        load = '0;
        if (accept && ch_valid) load[CFG_CH] = 1'b1;
    end

    always_ff @(posedge CLK100MHz or negedge RST_N) begin
        if (!RST_N) begin
            state     <= StIdle;
            tgt       <= '0;
            CFG_READY <= 1'b1;
        end else begin
            unique case (state)
                StIdle: begin
                    // Out-of-range channels are consumed without leaving idle.
                    if (accept && ch_valid) begin
                        tgt       <= CFG_CH;
                        CFG_READY <= 1'b0;
                        state     <= CFG_SYNC ? StAlign : StWaitWrap;
                    end
                end
                StWaitWrap: begin
                    if (!PENDING[tgt]) begin
                        CFG_READY <= 1'b1;
                        state     <= StIdle;
                    end
                end
                StAlign: begin
                    CFG_READY <= 1'b1;
                    state     <= StIdle;
                end
                default: begin
                    CFG_READY <= 1'b1;
                    state     <= StIdle;
                end
            endcase
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        clk_en_chan #(
            .CW         (CW),
            .DEFAULT_TC (DEFAULT_TC)
        ) u_chan (
            .clk     (CLK100MHz),
            .rst_n   (RST_N),
            .en      (EN_MASK[i]),
            .load    (load[i]),
            .load_tc (CFG_TC),
            .align   (align),
            .tick    (TICK[i]),
            .toggle  (TOGGLE[i]),
            .pend    (PENDING[i])
        );
    end

endmodule
